// File: rtl/vga_sync_decoder.sv
`default_nettype none
//==============================================================================
// Module   : vga_sync_decoder
// Brief    : Recovers 800x525 (640x480 active) timing from raw active-low VGA
//            syncs, locks onto it and emits coordinates and colour for every
//            active-region pixel, two cycles after the pins carry it.
// Options  : VGA_DEC_SIG_EN - adds a per-frame rotate/xor signature (frame_sig)
// Revision : 1.0 - initial release
//==============================================================================
module vga_sync_decoder #(
    parameter int H_SYNC   = 96,
    parameter int H_BACK   = 48,
    parameter int H_ACTIVE = 640,
    parameter int H_FRONT  = 16,
    parameter int V_SYNC   = 2,
    parameter int V_BACK   = 33,
    parameter int V_ACTIVE = 480,
    parameter int V_FRONT  = 10
) (
    input  logic        clk_clk,
    input  logic        reset_reset_n,
    input  logic        hsync_n,
    input  logic        vsync_n,
    input  logic [2:0]  color_r,
    input  logic [2:0]  color_g,
    input  logic [2:0]  color_b,
    output logic        pixel_valid,
    output logic [9:0]  pixel_x,
    output logic [9:0]  pixel_y,
    output logic [8:0]  pixel_rgb,
    output logic        frame_start,
    output logic        locked,
    output logic        timing_error
`ifdef VGA_DEC_SIG_EN
    ,
    output logic [15:0] frame_sig
`endif
);

    localparam logic [9:0] C_CNT_MAX     = 10'd1023;
    localparam logic [9:0] C_H_TOTAL_M1  = 10'(H_SYNC + H_BACK + H_ACTIVE + H_FRONT - 1);
    localparam logic [9:0] C_V_TOTAL_M1  = 10'(V_SYNC + V_BACK + V_ACTIVE + V_FRONT - 1);
    localparam logic [9:0] C_H_ACT_START = 10'(H_SYNC + H_BACK);
    localparam logic [9:0] C_H_ACT_END   = 10'(H_SYNC + H_BACK + H_ACTIVE - 1);
    localparam logic [9:0] C_V_ACT_START = 10'(V_SYNC + V_BACK);
    localparam logic [9:0] C_V_ACT_END   = 10'(V_SYNC + V_BACK + V_ACTIVE - 1);
    localparam logic [2:0] C_GOOD_LAST   = 3'd3;  // fourth consecutive good line

    typedef enum logic [1:0] {
        S_SEARCH = 2'd0,
        S_ALIGN  = 2'd1,
        S_LOCK   = 2'd2
    } state_t;

    // input capture stage and previous sync levels for edge detection
    logic       r_hs, r_vs, r_hs_d, r_vs_d;
    logic [8:0] r_rgb;
    // raster counters
    logic [9:0] r_hcnt, r_vcnt;
    logic       r_vs_seen;
    // lock state machine
    state_t     r_state;
    logic [2:0] r_good;
    logic       r_locked, r_timing_error;
    // pixel output stage
    logic       r_pix_valid, r_frame_start;
    logic [9:0] r_pix_x, r_pix_y;
    logic [8:0] r_pix_rgb;

    logic       w_hs_fall, w_vs_fall;
    logic [9:0] w_hcnt_inc, w_vcnt_inc, w_hcnt, w_vcnt;
    logic       w_line_ok, w_hsat, w_lock_err, w_active, w_pix_ok;

    // Edges and the counter values belonging to the pixel now in the capture stage
    assign w_hs_fall  = r_hs_d & ~r_hs;
    assign w_vs_fall  = r_vs_d & ~r_vs;
    assign w_hcnt_inc = (r_hcnt == C_CNT_MAX) ? C_CNT_MAX : r_hcnt + 10'd1;
    assign w_vcnt_inc = (r_vcnt == C_CNT_MAX) ? C_CNT_MAX : r_vcnt + 10'd1;
    assign w_hcnt     = w_hs_fall ? 10'd0 : w_hcnt_inc;
    assign w_vcnt     = !w_hs_fall                ? r_vcnt :
                        (r_vs_seen || w_vs_fall)  ? 10'd0  : w_vcnt_inc;

    // A line is good when the previous hcnt reached exactly total-1 before the new fall
    assign w_line_ok  = (r_hcnt == C_H_TOTAL_M1);
    assign w_hsat     = (w_hcnt == C_CNT_MAX);
    // r_vcnt still holds the last line of the ending frame when the vsync edge arrives
    assign w_lock_err = (r_state == S_LOCK) &&
                        ((w_hs_fall && !w_line_ok) ||
                         (w_vs_fall && (r_vcnt != C_V_TOTAL_M1)) ||
                         w_hsat);
    assign w_active   = (w_hcnt >= C_H_ACT_START) && (w_hcnt <= C_H_ACT_END) &&
                        (w_vcnt >= C_V_ACT_START) && (w_vcnt <= C_V_ACT_END);
    assign w_pix_ok   = w_active && (r_state == S_LOCK) && !w_lock_err;

    // Register the pins once; syncs reset to their idle (high) level
    always_ff @(posedge clk_clk) begin
        if (!reset_reset_n) begin
            r_hs   <= 1'b1;
            r_vs   <= 1'b1;
            r_hs_d <= 1'b1;
            r_vs_d <= 1'b1;
            r_rgb  <= 9'd0;
        end else begin
            r_hs   <= hsync_n;
            r_vs   <= vsync_n;
            r_hs_d <= r_hs;
            r_vs_d <= r_vs;
            r_rgb  <= {color_r, color_g, color_b};
        end
    end

    // Horizontal/vertical raster counters and the pending-vsync flag
    always_ff @(posedge clk_clk) begin
        if (!reset_reset_n) begin
            r_hcnt    <= 10'd0;
            r_vcnt    <= 10'd0;
            r_vs_seen <= 1'b0;
        end else begin
            r_hcnt    <= w_hcnt;
            r_vcnt    <= w_vcnt;
            r_vs_seen <= w_hs_fall ? 1'b0 : (w_vs_fall ? 1'b1 : r_vs_seen);
        end
    end

    // Lock acquisition: count good lines, align to vsync, then supervise timing
    always_ff @(posedge clk_clk) begin
        if (!reset_reset_n) begin
            r_state        <= S_SEARCH;
            r_good         <= 3'd0;
            r_locked       <= 1'b0;
            r_timing_error <= 1'b0;
        end else begin
            r_timing_error <= 1'b0;
            case (r_state)
                S_SEARCH: begin
                    if (w_hs_fall) begin
                        if (!w_line_ok) begin
                            r_good <= 3'd0;
                        end else if (r_good == C_GOOD_LAST) begin
                            r_good  <= 3'd0;
                            r_state <= S_ALIGN;
                        end else begin
                            r_good <= r_good + 3'd1;
                        end
                    end
                end
                S_ALIGN: begin
                    if (w_hs_fall && !w_line_ok) begin
                        r_state <= S_SEARCH;
                    end else if (w_vs_fall) begin
                        r_state  <= S_LOCK;
                        r_locked <= 1'b1;
                    end
                end
                S_LOCK: begin
                    if (w_lock_err) begin
                        r_state        <= S_SEARCH;
                        r_locked       <= 1'b0;
                        r_timing_error <= 1'b1;
                    end
                end
                default: begin
                    r_state  <= S_SEARCH;
                    r_locked <= 1'b0;
                end
            endcase
        end
    end

    // Pixel outputs; coordinates and colour hold their last value between pixels
    always_ff @(posedge clk_clk) begin
        if (!reset_reset_n) begin
            r_pix_valid   <= 1'b0;
            r_frame_start <= 1'b0;
            r_pix_x       <= 10'd0;
            r_pix_y       <= 10'd0;
            r_pix_rgb     <= 9'd0;
        end else begin
            r_pix_valid   <= w_pix_ok;
            r_frame_start <= w_pix_ok && (w_hcnt == C_H_ACT_START) && (w_vcnt == C_V_ACT_START);
            if (w_pix_ok) begin
                r_pix_x   <= w_hcnt - C_H_ACT_START;
                r_pix_y   <= w_vcnt - C_V_ACT_START;
                r_pix_rgb <= r_rgb;
            end
        end
    end

`ifdef VGA_DEC_SIG_EN
    logic [15:0] r_acc, r_frame_sig;

    // Rotate/xor signature over each locked frame, published at its closing vsync
    always_ff @(posedge clk_clk) begin
        if (!reset_reset_n) begin
            r_acc       <= 16'd0;
            r_frame_sig <= 16'd0;
        end else if ((r_state != S_LOCK) || w_lock_err) begin
            r_acc <= 16'd0;
        end else if (w_vs_fall) begin
            r_frame_sig <= r_acc;
            r_acc       <= 16'd0;
        end else if (r_pix_valid) begin
            r_acc <= {r_acc[14:0], r_acc[15]} ^ {7'b0, r_pix_rgb};
        end
    end

    assign frame_sig = r_frame_sig;
`endif

    assign pixel_valid  = r_pix_valid;
    assign pixel_x      = r_pix_x;
    assign pixel_y      = r_pix_y;
    assign pixel_rgb    = r_pix_rgb;
    assign frame_start  = r_frame_start;
    assign locked       = r_locked;
    assign timing_error = r_timing_error;

endmodule
`default_nettype wire

// File: tb/tb_vga_sync_decoder.sv
`default_nettype none
//==============================================================================
// Module   : tb_vga_sync_decoder
// Brief    : Scoreboard bench for vga_sync_decoder on a reduced raster
//            (26x15 total, 16x8 active) so that many frames fit in a short run.
// Revision : 1.0 - initial release
//==============================================================================
module tb_vga_sync_decoder;

    localparam int H_SYNC = 4, H_BACK = 4, H_ACTIVE = 16, H_FRONT = 2;
    localparam int V_SYNC = 2, V_BACK = 3, V_ACTIVE = 8,  V_FRONT = 2;
    localparam int H_TOTAL = H_SYNC + H_BACK + H_ACTIVE + H_FRONT;
    localparam int V_TOTAL = V_SYNC + V_BACK + V_ACTIVE + V_FRONT;
    localparam int H_ST = H_SYNC + H_BACK;
    localparam int V_ST = V_SYNC + V_BACK;
    localparam int NPIX = H_ACTIVE * V_ACTIVE;

    logic       clk_clk = 1'b0;
    logic       reset_reset_n;
    logic       hsync_n, vsync_n;
    logic [2:0] color_r, color_g, color_b;
    logic       pixel_valid, frame_start, locked, timing_error;
    logic [9:0] pixel_x, pixel_y;
    logic [8:0] pixel_rgb;
`ifdef VGA_DEC_SIG_EN
    logic [15:0] frame_sig;
`endif

    vga_sync_decoder #(
        .H_SYNC(H_SYNC), .H_BACK(H_BACK), .H_ACTIVE(H_ACTIVE), .H_FRONT(H_FRONT),
        .V_SYNC(V_SYNC), .V_BACK(V_BACK), .V_ACTIVE(V_ACTIVE), .V_FRONT(V_FRONT)
    ) dut (
        .clk_clk      (clk_clk),
        .reset_reset_n(reset_reset_n),
        .hsync_n      (hsync_n),
        .vsync_n      (vsync_n),
        .color_r      (color_r),
        .color_g      (color_g),
        .color_b      (color_b),
        .pixel_valid  (pixel_valid),
        .pixel_x      (pixel_x),
        .pixel_y      (pixel_y),
        .pixel_rgb    (pixel_rgb),
        .frame_start  (frame_start),
        .locked       (locked),
        .timing_error (timing_error)
`ifdef VGA_DEC_SIG_EN
        ,
        .frame_sig    (frame_sig)
`endif
    );

    always #5 clk_clk = ~clk_clk;

    typedef struct {
        int         cyc;
        logic [9:0] x;
        logic [9:0] y;
        logic [8:0] rgb;
        logic       fs;
    } exp_t;

    exp_t sb_q[$];
    int   n_cmp = 0, n_bad = 0;
    int   cyc = 0;
    int   pv_cnt = 0, fs_cnt = 0, te_cnt = 0, te_cyc = -1, rise_cyc = -1;
    bit   mon_en = 0, prev_locked = 0;
    logic [9:0] hold_x = '0, hold_y = '0;
    logic [8:0] hold_rgb = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // cycle counter: value k after the k-th rising edge
    initial forever begin
        @(posedge clk_clk);
        cyc++;
    end

    // monitor: pops the scoreboard on every presented pixel, checks hold otherwise
    initial begin
        exp_t e;
        forever begin
            @(negedge clk_clk);
            if (mon_en) begin
                if (pixel_valid === 1'b1) begin
                    pv_cnt++;
                    n_cmp++;
                    if (sb_q.size() == 0) begin
                        n_bad++;
                        $display("FAIL sb_unexpected: pixel x=%0d y=%0d rgb=%h at cycle %0d, none expected",
                                 pixel_x, pixel_y, pixel_rgb, cyc);
                    end else begin
                        e = sb_q.pop_front();
                        if (cyc != e.cyc + 2 || pixel_x !== e.x || pixel_y !== e.y ||
                            pixel_rgb !== e.rgb || frame_start !== e.fs) begin
                            n_bad++;
                            $display("FAIL sb_pixel: got x=%0d y=%0d rgb=%h fs=%b cyc=%0d, expected x=%0d y=%0d rgb=%h fs=%b cyc=%0d",
                                     pixel_x, pixel_y, pixel_rgb, frame_start, cyc,
                                     e.x, e.y, e.rgb, e.fs, e.cyc + 2);
                        end
                    end
                    hold_x   = pixel_x;
                    hold_y   = pixel_y;
                    hold_rgb = pixel_rgb;
                end else begin
                    check("hold_outputs", {3'b0, pixel_x, pixel_y, pixel_rgb},
                          {3'b0, hold_x, hold_y, hold_rgb});
                end
                if (frame_start === 1'b1) fs_cnt++;
                if (timing_error === 1'b1) begin
                    te_cnt++;
                    te_cyc = cyc;
                end
                if (locked === 1'b1 && !prev_locked) rise_cyc = cyc;
                prev_locked = (locked === 1'b1);
            end
        end
    end

    task automatic tick();
        @(posedge clk_clk);
        #1;
    endtask

    function automatic logic [8:0] pix_col(input int mode, input int x, input int y);
        case (mode)
            0:       return 9'(x * 37 + y * 11 + 5);
            1:       return (x == H_ACTIVE - 1 && y == 0) ? 9'h1FF : 9'h000;
            3:       return (x == 0 && y == 0) ? 9'h001 : 9'h000;
            default: return 9'h000;
        endcase
    endfunction

    task automatic check_all_zero(input string tag);
        check({tag, "_pixel_valid"},  pixel_valid, 0);
        check({tag, "_frame_start"},  frame_start, 0);
        check({tag, "_locked"},       locked, 0);
        check({tag, "_timing_error"}, timing_error, 0);
        check({tag, "_xy_rgb"},       {pixel_x, pixel_y, pixel_rgb}, 0);
`ifdef VGA_DEC_SIG_EN
        check({tag, "_frame_sig"},    frame_sig, 0);
`endif
    endtask

    // one full frame; short_line gets one cycle less, rst_line pulses reset mid-line
    task automatic drive_frame(input bit exp_lk, input int mode, input int short_line,
                               input int rst_line, output int f_stamp, output int err_stamp);
        bit         lk;
        bit         act;
        int         len;
        logic [8:0] c;
        exp_t       e;
        lk        = exp_lk;
        f_stamp   = cyc;
        err_stamp = -1;
        for (int l = 0; l < V_TOTAL; l++) begin
            len = (l == short_line) ? H_TOTAL - 1 : H_TOTAL;
            if (short_line >= 0 && l == short_line + 1) err_stamp = cyc;
            if (l == short_line) lk = 0;
            for (int h = 0; h < len; h++) begin
                act = (h >= H_ST && h < H_ST + H_ACTIVE && l >= V_ST && l < V_ST + V_ACTIVE);
                c   = act ? pix_col(mode, h - H_ST, l - V_ST) : ((mode == 0) ? 9'h155 : 9'h000);
                hsync_n = (h >= H_SYNC);
                vsync_n = (l >= V_SYNC);
                {color_r, color_g, color_b} = c;
                if (l == rst_line && h == 5) begin
                    reset_reset_n = 1'b0;
                    lk = 0;
                end
                if (act && lk) begin
                    e.cyc = cyc;
                    e.x   = 10'(h - H_ST);
                    e.y   = 10'(l - V_ST);
                    e.rgb = c;
                    e.fs  = (h == H_ST && l == V_ST);
                    sb_q.push_back(e);
                end
                tick();
                if (!reset_reset_n) begin
                    check_all_zero("midframe_reset");
                    hold_x = '0; hold_y = '0; hold_rgb = '0;
                    reset_reset_n = 1'b1;
                end
            end
        end
    endtask

    initial begin
        int fs, es, p0, f0, t0;
        reset_reset_n = 1'b0;
        hsync_n = 1'b1;
        vsync_n = 1'b1;
        {color_r, color_g, color_b} = 9'h0;
        repeat (3) tick();
        check_all_zero("reset");
        mon_en = 1;
        reset_reset_n = 1'b1;
        tick();

        // frame 0: acquisition, no lock yet
        drive_frame(0, 0, -1, -1, fs, es);
        check("locked_before_2nd_vs", locked, 0);

        // frame 1: lock at its vsync, full frame of pixels
        p0 = pv_cnt; f0 = fs_cnt;
        drive_frame(1, 0, -1, -1, fs, es);
        check("lock_rise_cycle_f1", rise_cyc, fs + 2);
        check("f1_pixel_count", pv_cnt - p0, NPIX);
        check("f1_frame_start_count", fs_cnt - f0, 1);
        check("f1_sb_drained", sb_q.size(), 0);

        // frame 2: single 1FF at last column of first active row
        p0 = pv_cnt;
        drive_frame(1, 1, -1, -1, fs, es);
        check("f2_pixel_count", pv_cnt - p0, NPIX);
        check("no_error_coincident_edges", te_cnt, 0);
        check("f2_locked", locked, 1);

        // frame 3: line 2 one cycle short
        p0 = pv_cnt; t0 = te_cnt;
        drive_frame(0, 0, 2, -1, fs, es);
        check("short_line_error_pulses", te_cnt - t0, 1);
        check("short_line_error_cycle", te_cyc, es + 2);
        check("short_line_no_pixels", pv_cnt - p0, 0);
        check("short_line_unlocked", locked, 0);
`ifdef VGA_DEC_SIG_EN
        check("sig_frame2", frame_sig, 16'h01FF);
`endif

        // frame 4: relock, constant black
        p0 = pv_cnt;
        drive_frame(1, 2, -1, -1, fs, es);
        check("lock_rise_cycle_f4", rise_cyc, fs + 2);
        check("f4_pixel_count", pv_cnt - p0, NPIX);

        // frame 5: single 001 at (0,0)
        drive_frame(1, 3, -1, -1, fs, es);
`ifdef VGA_DEC_SIG_EN
        check("sig_black_frame", frame_sig, 16'h0000);
`endif

        // frame 6: nominal, publishes frame 5 signature at its start
        drive_frame(1, 0, -1, -1, fs, es);
`ifdef VGA_DEC_SIG_EN
        check("sig_single_pixel", frame_sig, 16'h8000);
`endif

        // frame 7: one-cycle reset during line 8 (rows 0..2 already delivered)
        p0 = pv_cnt; t0 = te_cnt;
        drive_frame(1, 0, -1, 8, fs, es);
        check("reset_frame_pixels", pv_cnt - p0, 3 * H_ACTIVE);
        check("reset_no_error", te_cnt - t0, 0);
        check("reset_frame_unlocked", locked, 0);

        // frame 8: relock at the next vsync
        p0 = pv_cnt; f0 = fs_cnt;
        drive_frame(1, 0, -1, -1, fs, es);
        check("lock_rise_cycle_f8", rise_cyc, fs + 2);
        check("f8_pixel_count", pv_cnt - p0, NPIX);
        check("f8_frame_start_count", fs_cnt - f0, 1);

        repeat (4) tick();
        check("final_sb_drained", sb_q.size(), 0);
        check("total_errors", te_cnt, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/vga_sync_decoder.md
VGA_SYNC_DECODER -- requirements
Module: vga_sync_decoder

Interface
REQ-001 SHALL provide clk_clk, input, 1, the single clock; one pixel per cycle.
REQ-002 SHALL provide reset_reset_n, input, 1, synchronous active-low reset.
REQ-003 SHALL provide hsync_n, input, 1, active-low horizontal sync from the video generator.
REQ-004 SHALL provide vsync_n, input, 1, active-low vertical sync from the video generator.
REQ-005 SHALL provide color_r, color_g, color_b, input, 3 each, pixel colour.
REQ-006 SHALL provide pixel_valid, output, 1, high for an active-region pixel while locked.
REQ-007 SHALL provide pixel_x, output, 10, column 0..639; pixel_y, output, 10, row 0..479.
REQ-008 SHALL provide pixel_rgb, output, 9, {r,g,b} of the current pixel.
REQ-009 SHALL provide frame_start, output, 1, one-cycle pulse on the first active pixel of each locked frame.
REQ-010 SHALL provide locked, output, 1, high while timing matches 640x480.
REQ-011 SHALL provide timing_error, output, 1, one-cycle pulse when lock is lost.
REQ-012 SHALL provide frame_sig, output, 16, frame signature (only when VGA_DEC_SIG_EN is defined).

Function
REQ-013 SHALL register all inputs once; every decoding step uses the registered copies.
REQ-014 SHALL detect an hsync falling edge (hs_fall) as registered hsync_n going 1->0; vs_fall likewise.
REQ-015 SHALL run hcnt (10 bit): 0 on hs_fall, else +1, saturating at 1023.
REQ-016 SHALL latch a vs_seen flag on vs_fall and clear it at the next hs_fall, including when both occur in the same cycle.
REQ-017 SHALL update vcnt (10 bit) on hs_fall only: 0 if vs_seen or vs_fall, else +1, saturating at 1023.
REQ-018 SHALL define the active region as hcnt in 144..783 and vcnt in 35..514; pixel_x = hcnt-144, pixel_y = vcnt-35.
REQ-019 SHALL implement states SEARCH, ALIGN, LOCK.
REQ-020 SHALL, in SEARCH, count consecutive lines whose hs_fall-to-hs_fall period is exactly 800 cycles; any other period resets the count; at 4 good lines it moves to ALIGN.
REQ-021 SHALL, in ALIGN, move to LOCK on the next vs_fall; a bad line period returns it to SEARCH.
REQ-022 SHALL, in LOCK, check every line period = 800 and every frame = 525 lines (vcnt = 524 at vs_fall); a mismatch or hcnt saturating pulses timing_error and returns to SEARCH in the same cycle.
REQ-023 SHALL hold locked = 1 exactly while in LOCK.
REQ-024 SHALL drive pixel_valid, pixel_x, pixel_y and pixel_rgb 2 cycles after the pins carry that pixel; pixel_valid SHALL be 0 outside the active region or when not locked.
REQ-025 SHALL hold pixel_x, pixel_y and pixel_rgb at their last values while pixel_valid = 0.
REQ-026 SHALL pulse frame_start together with pixel_valid at pixel_x = 0, pixel_y = 0.
REQ-027 SHALL produce the first frame_start of a lock no earlier than the frame after the vs_fall that entered LOCK.

Reset
REQ-028 SHALL, while reset_reset_n = 0 at a clock edge, set state SEARCH and clear hcnt, vcnt, vs_seen, the good-line count, frame_sig and its accumulator.
REQ-029 SHALL, under reset, drive pixel_valid, frame_start, locked, timing_error, pixel_x, pixel_y and pixel_rgb to 0.
REQ-030 SHALL abandon any lock when reset is asserted mid-frame, with no timing_error pulse.

Configuration
REQ-031 SHALL, with VGA_DEC_SIG_EN defined, accumulate acc = {acc[14:0], acc[15]} ^ {7'b0, pixel_rgb} on each pixel_valid and copy acc to frame_sig at the vs_fall that ends a locked frame.
REQ-032 SHALL clear acc at that same vs_fall, and on every loss of lock.
REQ-033 SHALL, without VGA_DEC_SIG_EN, omit frame_sig, the accumulator and the frame_sig port entirely.

Verification
REQ-034 SHALL cover nominal lock: standard 800x525 timing from reset -> locked rises at the second vs_fall, the next frame gives frame_start once and exactly 307200 pixel_valid cycles.
REQ-035 SHALL cover coordinates and latency: colour 9'h1FF driven only at hcnt = 144+639, line 35 -> pixel_valid 2 cycles later with pixel_x = 639, pixel_y = 0, pixel_rgb = 9'h1FF.
REQ-036 SHALL cover a short line: one line of 799 cycles while locked -> timing_error pulses once, locked falls, and pixel_valid stays 0 until lock is regained.
REQ-037 SHALL cover a coincident edge: vs_fall and hs_fall in the same cycle -> vcnt = 0 on the next line and no error.
REQ-038 SHALL cover mid-frame reset: reset_reset_n low for 1 cycle at line 200 -> all outputs 0 the next cycle, no timing_error, relock after the next full frame.
REQ-039 SHALL cover the signature (VGA_DEC_SIG_EN): a constant 9'h000 frame -> frame_sig = 16'h0000; a single pixel 9'h001 at (0,0) -> frame_sig = 16'h0001 rotated left 307199 mod 16 = 15 places = 16'h8000.
